// File: rtl/cmd_serializer.sv
// ---------------------------------------------------------------------------
// cmd_serializer
//
// Transmits one 48-bit SD command frame on the CMD line each time the start
// detector raises start_flag. The frame goes out MSB first:
//   start(0), tx(1), index[5:0], argument[31:0], crc7[6:0], end(1)
// Each bit is held for DIV clk cycles. The bit-rate tick comes from an
// internal divider.
//
// Build option:
//   SD_CMD_CRC7_EN  defined   : CRC7 (x^7+x^3+1) is computed serially over
//                               frame bits 47..8, and cmd_crc_in is ignored.
//                   undefined : cmd_crc_in is captured with the command and
//                               sent as the CRC field.
//
// Parameters:
//   DIV    clk cycles per CMD bit (2..255)
//   CNT_W  divider counter width (must hold DIV-1)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   start_flag    one-cycle frame request
//   cmd_index     command index, captured on accept
//   cmd_argument  command argument, captured on accept
//   cmd_crc_in    external CRC7, used only without SD_CMD_CRC7_EN
//   cmd_out       serial CMD data to the pad (idles high)
//   cmd_oe        pad output enable, high while the frame is driven
//   busy          high while the frame bits are being sent
//   done          one-cycle pulse after the end bit
//   overrun       one-cycle pulse, start_flag seen while not idle
// ---------------------------------------------------------------------------
module cmd_serializer #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_flag,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_argument,
  input  logic [6:0]  cmd_crc_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [5:0]        bit_cnt;
  logic [CNT_W-1:0]  div_cnt;
  logic [39:0]       shreg;
  logic [6:0]        crc;
  logic              accept;
  logic              bit_end;
  logic              frame_bit;

  assign accept  = (state == S_IDLE) && start_flag;
  assign bit_end = (state == S_SEND) && (div_cnt == DIV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_flag)                   state_nxt = S_SEND;
      S_SEND:  if (bit_end && (bit_cnt == 6'd0)) state_nxt = S_DONE;
      S_DONE:                                    state_nxt = S_IDLE;
      default:                                   state_nxt = S_IDLE;
    endcase
  end

  // Current frame bit: header/argument from the shift register, then the
  // CRC field MSB first (bit_cnt 7..1 maps to crc[6..0]), then the end bit.
  always_comb begin
    frame_bit = 1'b1;
    if (bit_cnt >= 6'd8)       frame_bit = shreg[39];
    else if (bit_cnt != 6'd0)  frame_bit = crc[bit_cnt[2:0] - 3'd1];
  end

  // Output logic
  always_comb begin
    cmd_out = 1'b1;
    cmd_oe  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_SEND: begin
        cmd_out = frame_bit;
        cmd_oe  = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Bit and divider counters. bit_cnt parks at 0 after the end bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= 6'd0;
      div_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= 6'd47;
      div_cnt <= '0;
    end else if (state == S_SEND) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Overrun: any request outside IDLE is dropped and flagged next cycle.
  always_ff @(posedge clk) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= start_flag && (state != S_IDLE);
  end

  // Header/argument shift register; data only, no reset needed because
  // cmd_out is forced high outside SEND.
  always_ff @(posedge clk) begin
    if (accept)       shreg <= {2'b01, cmd_index, cmd_argument};
    else if (bit_end) shreg <= {shreg[38:0], 1'b0};
  end

`ifdef SD_CMD_CRC7_EN
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  logic unused_crc_in;
  assign unused_crc_in = ^cmd_crc_in;

  // CRC advances once per header/argument bit, on that bit's last cycle,
  // so it is final before bit 7 goes out.
  always_ff @(posedge clk) begin
    if (reset || accept)                  crc <= 7'd0;
    else if (bit_end && bit_cnt >= 6'd8)  crc <= crc7_step(crc, shreg[39]);
  end
`else
  always_ff @(posedge clk) begin
    if (reset)       crc <= 7'd0;
    else if (accept) crc <= cmd_crc_in;
  end
`endif

endmodule

// File: tb/tb_cmd_serializer.sv
// ---------------------------------------------------------------------------
// tb_cmd_serializer
//
// Directed bench for cmd_serializer with DIV=4. cmd_crc_in is always driven
// with the true CRC7 of the command, so the expected frames are the same
// with or without SD_CMD_CRC7_EN. After each accept the inputs are
// scrambled to show that only the accept-edge values are transmitted.
// Outputs are sampled on the falling edge. A frame bit is read on the
// second cycle of its DIV-cycle slot.
// ---------------------------------------------------------------------------
module tb_cmd_serializer;

  localparam int DIV = 4;
  localparam int WIN = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_flag;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic [6:0]  cmd_crc_in;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;
  logic        overrun;

  always #5 clk = ~clk;

  cmd_serializer #(.DIV(DIV), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_flag   (start_flag),
    .cmd_index    (cmd_index),
    .cmd_argument (cmd_argument),
    .cmd_crc_in   (cmd_crc_in),
    .cmd_out      (cmd_out),
    .cmd_oe       (cmd_oe),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic out_s  [WIN];
  logic oe_s   [WIN];
  logic busy_s [WIN];
  logic done_s [WIN];
  logic ovr_s  [WIN];

  localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_CMD17 = 48'h51_0000_0000_55;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge. Requests a frame at the next rising edge
  // (cycle 0 is the first cycle after that accept edge), records ncyc
  // cycles, and optionally injects a second start or a reset pulse.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input int ncyc,
                           input int inj_cyc, input logic [5:0] inj_idx,
                           input logic [31:0] inj_arg, input logic [6:0] inj_crc,
                           input int rst_cyc);
    start_flag   = 1'b1;
    reset        = 1'b0;
    cmd_index    = idx;
    cmd_argument = arg;
    cmd_crc_in   = crc;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      out_s[k]  = cmd_out;
      oe_s[k]   = cmd_oe;
      busy_s[k] = busy;
      done_s[k] = done;
      ovr_s[k]  = overrun;
      start_flag = (k == inj_cyc);
      reset      = (k == rst_cyc);
      if (k == 0) begin
        cmd_index    = ~idx;
        cmd_argument = ~arg;
        cmd_crc_in   = ~crc;
      end
      if (k == inj_cyc) begin
        cmd_index    = inj_idx;
        cmd_argument = inj_arg;
        cmd_crc_in   = inj_crc;
      end
    end
    start_flag = 1'b0;
    reset      = 1'b0;
  endtask

  function automatic logic [47:0] frame_at(input int off);
    logic [47:0] f;
    for (int i = 0; i < 48; i++) f[47-i] = out_s[off + i*DIV + 1];
    return f;
  endfunction

  function automatic int count_hi(input logic a [WIN], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (a[i]) c++;
    return c;
  endfunction

  initial begin
    reset        = 1'b1;
    start_flag   = 1'b1;
    cmd_index    = 6'd0;
    cmd_argument = 32'd0;
    cmd_crc_in   = 7'd0;
    repeat (3) @(negedge clk);

    // Reset state, with start_flag held high to show reset wins
    check_val("rst_cmd_out", cmd_out, 1'b1);
    check_val("rst_cmd_oe",  cmd_oe,  1'b0);
    check_val("rst_busy",    busy,    1'b0);
    check_val("rst_done",    done,    1'b0);
    check_val("rst_overrun", overrun, 1'b0);
    start_flag = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    check_val("idle_cmd_oe", cmd_oe, 1'b0);

    // T1 CMD0
    run_frame(6'd0, 32'd0, 7'h4A, 200, -1, 6'd0, 32'd0, 7'd0, -1);
    check_val("t1_frame",      frame_at(0), F_CMD0);
    check_val("t1_first_oe",   oe_s[0], 1'b1);
    check_val("t1_oe_cycles",  count_hi(oe_s, 200), 192);
    check_val("t1_busy_cyc",   count_hi(busy_s, 200), 192);
    check_val("t1_done_cnt",   count_hi(done_s, 200), 1);
    check_val("t1_done_at",    done_s[192], 1'b1);
    check_val("t1_done_oe",    oe_s[192], 1'b0);
    check_val("t1_done_out",   out_s[192], 1'b1);
    check_val("t1_no_ovr",     count_hi(ovr_s, 200), 0);

    // T2 CMD8
    run_frame(6'd8, 32'h0000_01AA, 7'h43, 200, -1, 6'd0, 32'd0, 7'd0, -1);
    check_val("t2_frame",      frame_at(0), F_CMD8);
    check_val("t2_oe_cycles",  count_hi(oe_s, 200), 192);

    // T3 CMD17
    run_frame(6'd17, 32'd0, 7'h2A, 200, -1, 6'd0, 32'd0, 7'd0, -1);
    check_val("t3_frame",      frame_at(0), F_CMD17);
    check_val("t3_done_at",    done_s[192], 1'b1);

    // T4 start during bit 20 (cycles 108..111)
    run_frame(6'd0, 32'd0, 7'h4A, 300, 109, 6'd63, 32'hDEAD_BEEF, 7'h7F, -1);
    check_val("t4_frame",      frame_at(0), F_CMD0);
    check_val("t4_ovr_at",     ovr_s[110], 1'b1);
    check_val("t4_ovr_cnt",    count_hi(ovr_s, 300), 1);
    check_val("t4_no_2nd",     count_hi(oe_s, 300), 192);
    check_val("t4_done_cnt",   count_hi(done_s, 300), 1);

    // T5 reset during bit 30 (cycles 68..71)
    run_frame(6'd8, 32'h0000_01AA, 7'h43, 200, -1, 6'd0, 32'd0, 7'd0, 69);
    check_val("t5_oe_before",  oe_s[69], 1'b1);
    check_val("t5_oe_after",   oe_s[70], 1'b0);
    check_val("t5_out_after",  out_s[70], 1'b1);
    check_val("t5_busy_after", busy_s[70], 1'b0);
    check_val("t5_oe_cycles",  count_hi(oe_s, 200), 70);
    check_val("t5_no_done",    count_hi(done_s, 200), 0);
    run_frame(6'd17, 32'd0, 7'h2A, 200, -1, 6'd0, 32'd0, 7'd0, -1);
    check_val("t5_recover",    frame_at(0), F_CMD17);

    // T6 back-to-back: new start in the IDLE cycle right after DONE
    run_frame(6'd0, 32'd0, 7'h4A, WIN, 193, 6'd8, 32'h0000_01AA, 7'h43, -1);
    check_val("t6_frame1",     frame_at(0), F_CMD0);
    check_val("t6_done1",      done_s[192], 1'b1);
    check_val("t6_gap_oe",     oe_s[192], 1'b0);
    check_val("t6_accept_oe",  oe_s[193], 1'b0);
    check_val("t6_frame2_oe",  oe_s[194], 1'b1);
    check_val("t6_frame2",     frame_at(194), F_CMD8);
    check_val("t6_done2",      done_s[386], 1'b1);
    check_val("t6_no_ovr",     count_hi(ovr_s, WIN), 0);
    check_val("t6_oe_cycles",  count_hi(oe_s, WIN), 384);

    // T7 start in the last SEND cycle, as DONE is entered
    run_frame(6'd17, 32'd0, 7'h2A, 250, 191, 6'd8, 32'h0000_01AA, 7'h43, -1);
    check_val("t7_frame",      frame_at(0), F_CMD17);
    check_val("t7_ovr_at",     ovr_s[192], 1'b1);
    check_val("t7_no_2nd",     count_hi(oe_s, 250), 192);

    // T8 start during the DONE cycle
    run_frame(6'd0, 32'd0, 7'h4A, 250, 192, 6'd8, 32'h0000_01AA, 7'h43, -1);
    check_val("t8_frame",      frame_at(0), F_CMD0);
    check_val("t8_ovr_at",     ovr_s[193], 1'b1);
    check_val("t8_ovr_cnt",    count_hi(ovr_s, 250), 1);
    check_val("t8_no_2nd",     count_hi(oe_s, 250), 192);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
